// File: rtl/spi_reg_bridge_if.sv
// spi_reg_bridge_if: ULPI register-access port between the SPI bridge (master) and the ULPI side (slave)
interface spi_reg_bridge_if;
  logic       reg_req;
  logic       reg_we;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_ack;
  logic [7:0] reg_rdata;
  modport master (output reg_req, reg_we, reg_addr, reg_wdata, input reg_ack, reg_rdata);
  modport slave  (input reg_req, reg_we, reg_addr, reg_wdata, output reg_ack, reg_rdata);
endinterface

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: decodes SPI command/data bytes into ULPI register reads/writes with auto-increment bursts
module spi_reg_bridge #(
  parameter logic [3:0] STATUS_ID   = 4'h1,
  parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    nCS,
  input  logic [7:0]              mosi_data,
  input  logic                    data_next,
  output logic [7:0]              miso_data,
  output logic                    err,
  spi_reg_bridge_if.master        bus
);
  typedef enum logic [2:0] {IDLE, CMD, WR_DATA, WR_BUSY, RD_BUSY, RD_WAIT} state_t;
  state_t     state_q;
  logic [1:0] ncs_q;
  logic       dn_q, req_q, we_q, err_q, trk_q;
  logic [5:0] addr_q;
  logic [7:0] wdata_q, miso_q, cnt_q;
  logic       frame, stb, ack, tmo, done;
  logic [7:0] status;
  assign frame  = ~ncs_q[1];
  assign stb    = data_next & ~dn_q;
  assign ack    = req_q & bus.reg_ack;
  assign tmo    = req_q & ~bus.reg_ack & (cnt_q == ACK_TIMEOUT - 8'd1);
  assign done   = ack | tmo;
  assign status = {err_q, req_q, 2'b00, STATUS_ID};
  // trk_q selects the live status byte; cleared once read data has been captured
  assign miso_data     = trk_q ? status : miso_q;
  assign err           = err_q;
  assign bus.reg_req   = req_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ncs_q   <= 2'b11;
      dn_q    <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      trk_q   <= 1'b1;
      addr_q  <= 6'd0;
      wdata_q <= 8'd0;
      miso_q  <= 8'd0;
      cnt_q   <= 8'd0;
    end else begin
      ncs_q <= {ncs_q[0], nCS};
      dn_q  <= data_next;
      cnt_q <= (req_q && !done) ? cnt_q + 8'd1 : 8'd0;
      if ((stb && req_q) || tmo) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          trk_q <= 1'b1;
          if (frame) state_q <= CMD;
        end
        CMD:
          if (stb) begin
            addr_q <= mosi_data[5:0];
            if (mosi_data[6]) err_q <= 1'b0;
            if (mosi_data[7]) begin
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              state_q <= RD_BUSY;
            end else state_q <= WR_DATA;
          end else if (!frame) state_q <= IDLE;
        WR_DATA:
          if (stb) begin
            wdata_q <= mosi_data;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            state_q <= WR_BUSY;
          end else if (!frame) state_q <= IDLE;
        WR_BUSY:
          if (done) begin
            req_q   <= 1'b0;
            addr_q  <= addr_q + 6'd1;
            state_q <= frame ? WR_DATA : IDLE;
          end
        RD_BUSY:
          if (done) begin
            req_q   <= 1'b0;
            miso_q  <= ack ? bus.reg_rdata : 8'hFF;
            trk_q   <= ~frame;
            state_q <= frame ? RD_WAIT : IDLE;
          end
        RD_WAIT:
          if (stb) begin
            addr_q  <= addr_q + 6'd1;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            state_q <= RD_BUSY;
          end else if (!frame) begin
            trk_q   <= 1'b1;
            state_q <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed byte sequences against hand-computed register requests and MISO bytes
module tb_spi_reg_bridge;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       nCS = 1'b1;
  logic [7:0] mosi_data = 8'h00;
  logic       data_next = 1'b0;
  logic [7:0] miso_data;
  logic       err;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         rises = 0;
  int         n;
  logic       req_prev = 1'b0;
  spi_reg_bridge_if bus();
  spi_reg_bridge dut (
    .clk(clk), .reset(reset), .nCS(nCS), .mosi_data(mosi_data), .data_next(data_next),
    .miso_data(miso_data), .err(err), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.reg_req && !req_prev) rises++;
    req_prev = bus.reg_req;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input int hold);
    mosi_data = b;
    data_next = 1'b1;
    repeat (hold) tick();
    data_next = 1'b0;
    tick();
  endtask
  task automatic ack(input logic [7:0] rd);
    bus.reg_rdata = rd;
    bus.reg_ack = 1'b1;
    tick();
    bus.reg_ack = 1'b0;
  endtask
  task automatic frame_on();
    nCS = 1'b0;
    repeat (3) tick();
  endtask
  task automatic frame_off();
    nCS = 1'b1;
    repeat (4) tick();
  endtask
  initial begin
    bus.reg_ack = 1'b0;
    bus.reg_rdata = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_miso", miso_data, 8'h01);
    chk("rst_req", bus.reg_req, 0);
    chk("rst_we", bus.reg_we, 0);
    chk("rst_addr", bus.reg_addr, 0);
    chk("rst_wdata", bus.reg_wdata, 0);
    chk("rst_err", err, 0);
    // single write with one-cycle request latency
    frame_on();
    send(8'h05, 1);
    mosi_data = 8'hA5;
    data_next = 1'b1;
    chk("wr_req_pre", bus.reg_req, 0);
    tick();
    chk("wr_req_lat", bus.reg_req, 1);
    data_next = 1'b0;
    tick();
    chk("wr_we", bus.reg_we, 1);
    chk("wr_addr", bus.reg_addr, 6'h05);
    chk("wr_wdata", bus.reg_wdata, 8'hA5);
    chk("wr_busy_miso", miso_data, 8'h41);
    ack(8'h00);
    chk("wr_req_drop", bus.reg_req, 0);
    chk("wr_addr_inc", bus.reg_addr, 6'h06);
    frame_off();
    // burst write across the address wrap
    frame_on();
    send(8'h3F, 1);
    chk("bw_miso1", miso_data, 8'h01);
    send(8'h11, 1);
    chk("bw_addr0", bus.reg_addr, 6'h3F);
    chk("bw_wdata0", bus.reg_wdata, 8'h11);
    ack(8'h00);
    chk("bw_miso2", miso_data, 8'h01);
    chk("bw_wrap", bus.reg_addr, 6'h00);
    send(8'h22, 1);
    chk("bw_req1", bus.reg_req, 1);
    chk("bw_addr1", bus.reg_addr, 6'h00);
    chk("bw_wdata1", bus.reg_wdata, 8'h22);
    ack(8'h00);
    frame_off();
    // read burst
    frame_on();
    send(8'h8A, 1);
    chk("rd_req0", bus.reg_req, 1);
    chk("rd_we0", bus.reg_we, 0);
    chk("rd_addr0", bus.reg_addr, 6'h0A);
    ack(8'h5C);
    chk("rd_miso0", miso_data, 8'h5C);
    chk("rd_req_drop", bus.reg_req, 0);
    send(8'h00, 1);
    chk("rd_addr1", bus.reg_addr, 6'h0B);
    chk("rd_miso_hold", miso_data, 8'h5C);
    ack(8'h77);
    chk("rd_miso1", miso_data, 8'h77);
    frame_off();
    chk("rd_idle_miso", miso_data, 8'h01);
    // overrun: byte arrives while the write is still pending
    n = rises;
    frame_on();
    send(8'h05, 1);
    send(8'h01, 1);
    send(8'h02, 1);
    chk("ov_err", err, 1);
    chk("ov_wdata", bus.reg_wdata, 8'h01);
    chk("ov_writes", rises - n, 1);
    chk("ov_miso", miso_data, 8'hC1);
    ack(8'h00);
    frame_off();
    frame_on();
    send(8'h40, 1);
    chk("clr_err", err, 0);
    frame_off();
    // read timeout
    frame_on();
    mosi_data = 8'h81;
    data_next = 1'b1;
    tick();
    data_next = 1'b0;
    n = 0;
    while (bus.reg_req && n < 400) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 255);
    chk("to_err", err, 1);
    chk("to_miso", miso_data, 8'hFF);
    frame_off();
    chk("to_idle_miso", miso_data, 8'h81);
    // long data_next level, frame end while write pending
    frame_on();
    send(8'h40, 1);
    n = rises;
    send(8'h33, 3);
    chk("lvl_writes", rises - n, 1);
    chk("lvl_err", err, 0);
    chk("lvl_wdata", bus.reg_wdata, 8'h33);
    nCS = 1'b1;
    repeat (6) tick();
    chk("end_req_held", bus.reg_req, 1);
    ack(8'h00);
    chk("end_req_drop", bus.reg_req, 0);
    tick();
    n = rises;
    send(8'h99, 1);
    tick();
    chk("idle_stb_ignored", rises - n, 0);
    chk("idle_miso", miso_data, 8'h01);
    // reset in the middle of a read
    frame_on();
    send(8'h85, 1);
    chk("mr_req", bus.reg_req, 1);
    nCS = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_req_clr", bus.reg_req, 0);
    chk("mr_addr_clr", bus.reg_addr, 0);
    ack(8'h3C);
    chk("mr_ack_ignored", miso_data, 8'h01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
